// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through an external combinational ALU,
// registering the result and chaining carry/borrow between requests.
module alu_op_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  input  logic             flag_clr,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_control,
  output logic             alu_c_in,
  output logic             alu_b_in,
  input  logic [3:0]       alu_c,
  input  logic             alu_c_out,
  input  logic             alu_b_out,
  input  logic [1:0]       alu_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic [1:0]       out_cmp,
  output logic [2:0]       out_op,
  output logic             carry_flag,
  output logic             borrow_flag,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;

  state_t     state, state_nx;
  logic [3:0] a_q, b_q;
  logic [2:0] op_q;
  logic       chain_q;
  logic       in_xfer, out_xfer;
  logic       in_exec;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = EXEC;
      end
      EXEC: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          state_nx = in_valid ? EXEC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign in_exec  = (state == EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ALU inputs come only from the captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      chain_q <= 1'b0;
    end else if (in_xfer) begin
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= in_op;
      chain_q <= in_chain;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign alu_c_in    = carry_flag & chain_q;
  assign alu_b_in    = borrow_flag & chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_carry  <= 1'b0;
      out_borrow <= 1'b0;
      out_cmp    <= '0;
      out_op     <= '0;
    end else if (in_exec) begin
      out_result <= alu_c;
      out_carry  <= alu_c_out;
      out_borrow <= alu_b_out;
      out_cmp    <= alu_cmp;
      out_op     <= op_q;
    end
  end

  // clear wins over a same-cycle flag load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag  <= 1'b0;
      borrow_flag <= 1'b0;
    end else if (flag_clr) begin
      carry_flag  <= 1'b0;
      borrow_flag <= 1'b0;
    end else if (in_exec) begin
      if (op_q == OP_ADD) carry_flag  <= alu_c_out;
      if (op_q == OP_SUB) borrow_flag <= alu_b_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ops_done <= '0;
    else if (out_xfer) ops_done <= ops_done + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus a randomized
// run against a transaction-level model with a behavioural 4-bit ALU.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_chain = 1'b0;
  logic       flag_clr = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_control;
  logic       alu_c_in, alu_b_in;
  logic [3:0] alu_c;
  logic       alu_c_out, alu_b_out;
  logic [1:0] alu_cmp;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_carry, out_borrow;
  logic [1:0] out_cmp;
  logic [2:0] out_op;
  logic       carry_flag, borrow_flag;
  logic [7:0] ops_done;

  int total = 0;
  int bad   = 0;
  int unsigned exp_ops = 0;

  alu_op_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_chain(in_chain), .flag_clr(flag_clr),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control),
    .alu_c_in(alu_c_in), .alu_b_in(alu_b_in),
    .alu_c(alu_c), .alu_c_out(alu_c_out),
    .alu_b_out(alu_b_out), .alu_cmp(alu_cmp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_borrow(out_borrow), .out_cmp(out_cmp),
    .out_op(out_op),
    .carry_flag(carry_flag), .borrow_flag(borrow_flag),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // returns {result, c_out, b_out, cmp}
  function automatic logic [7:0] alu_ref(
    input logic [3:0] a, input logic [3:0] b,
    input logic [2:0] op, input logic ci, input logic bi);
    logic [4:0] s;
    logic [3:0] c;
    logic       co, bo;
    logic [1:0] cm;
    c = '0; co = 1'b0; bo = 1'b0; cm = 2'b00;
    case (op)
      3'b000: c = a & b;
      3'b001: begin
        s = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        c = s[3:0]; co = s[4];
      end
      3'b010: begin
        s = {1'b0, a} - {1'b0, b} - {4'b0, bi};
        c = s[3:0]; bo = s[4];
      end
      3'b011: cm = (a > b) ? 2'b01 : (a < b) ? 2'b10 : 2'b00;
      3'b100: c = a | b;
      3'b101: c = a ^ b;
      3'b110: c = ~a;
      default: c = a << b[1:0];
    endcase
    return {c, co, bo, cm};
  endfunction

  assign {alu_c, alu_c_out, alu_b_out, alu_cmp} =
    alu_ref(alu_a, alu_b, alu_control, alu_c_in, alu_b_in);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
  endtask

  // leaves the DUT in DONE with out_ready low
  task automatic run_op(
    input logic [3:0] a, input logic [3:0] b,
    input logic [2:0] op, input logic ch, input logic clr,
    output logic cin_seen);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_chain = ch;
    flag_clr = clr; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cin_seen = alu_c_in;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    n = 0;
    while (!out_valid && n < 5) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL run_op_done got=%b want=1", out_valid);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_ops++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, ops_done, carry_flag, borrow_flag,
         out_result} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state got=%b/%b/%h/%b/%b/%h want=0/1/00/0/0/0",
        out_valid, in_ready, ops_done, carry_flag, borrow_flag, out_result);
    end
  endtask

  task automatic test_carry_chain();
    logic ci;
    run_op(4'hF, 4'h1, 3'b001, 1'b0, 1'b0, ci);
    total++;
    if ({out_result, out_carry, carry_flag} !== {4'h0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL carry1 got=%h/%b/%b want=0/1/1",
        out_result, out_carry, carry_flag);
    end
    drain();
    run_op(4'h0, 4'h0, 3'b001, 1'b1, 1'b0, ci);
    total++;
    if (ci !== 1'b1) begin
      bad++;
      $display("FAIL carry2_cin got=%b want=1", ci);
    end
    total++;
    if ({out_result, carry_flag} !== {4'h1, 1'b0}) begin
      bad++;
      $display("FAIL carry2 got=%h/%b want=1/0", out_result, carry_flag);
    end
    drain();
  endtask

  task automatic test_borrow_chain();
    logic ci;
    run_op(4'h3, 4'h5, 3'b010, 1'b0, 1'b0, ci);
    total++;
    if ({out_result, out_borrow, borrow_flag} !== {4'hE, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL borrow1 got=%h/%b/%b want=e/1/1",
        out_result, out_borrow, borrow_flag);
    end
    drain();
    run_op(4'h2, 4'h0, 3'b010, 1'b1, 1'b0, ci);
    total++;
    if ({out_result, borrow_flag} !== {4'h1, 1'b0}) begin
      bad++;
      $display("FAIL borrow2 got=%h/%b want=1/0", out_result, borrow_flag);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    logic ci;
    logic [7:0] ops_before;
    run_op(4'h5, 4'h6, 3'b001, 1'b0, 1'b0, ci);
    ops_before = 8'(exp_ops);
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 4'hB}) begin
        bad++;
        $display("FAIL bp_hold got=%b/%b/%h want=1/0/b",
          out_valid, in_ready, out_result);
      end
    end
    @(negedge clk);
    in_a = 4'h7; in_b = 4'h2; in_op = 3'b101; in_chain = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready got=%b want=1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    exp_ops++;
    total++;
    if ({out_valid, in_ready, ops_done} !==
        {1'b0, 1'b0, ops_before + 8'd1}) begin
      bad++;
      $display("FAIL bp_accept got=%b/%b/%h want=0/0/%h",
        out_valid, in_ready, ops_done, ops_before + 8'd1);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_result, out_op} !== {1'b1, 4'h5, 3'b101}) begin
      bad++;
      $display("FAIL bp_next got=%b/%h/%b want=1/5/101",
        out_valid, out_result, out_op);
    end
    drain();
  endtask

  task automatic test_flag_clr();
    logic ci;
    run_op(4'hF, 4'h1, 3'b001, 1'b0, 1'b1, ci);
    total++;
    if ({out_carry, carry_flag} !== {1'b1, 1'b0}) begin
      bad++;
      $display("FAIL flag_clr got=%b/%b want=1/0", out_carry, carry_flag);
    end
    drain();
  endtask

  task automatic test_cmp_shift();
    logic ci;
    run_op(4'hF, 4'h1, 3'b001, 1'b0, 1'b0, ci);
    drain();
    run_op(4'h3, 4'h5, 3'b010, 1'b0, 1'b0, ci);
    drain();
    run_op(4'h9, 4'h4, 3'b011, 1'b0, 1'b0, ci);
    total++;
    if ({out_cmp, carry_flag, borrow_flag} !== {2'b01, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL cmp got=%b/%b/%b want=01/1/1",
        out_cmp, carry_flag, borrow_flag);
    end
    drain();
    run_op(4'h3, 4'h1, 3'b111, 1'b1, 1'b0, ci);
    total++;
    if ({out_result, carry_flag, borrow_flag} !== {4'h6, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL shift got=%h/%b/%b want=6/1/1",
        out_result, carry_flag, borrow_flag);
    end
    drain();
  endtask

  task automatic test_reset_in_done();
    logic ci;
    run_op(4'hF, 4'h1, 3'b001, 1'b0, 1'b0, ci);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_result, carry_flag, ops_done, in_ready} !==
        {1'b0, 4'h0, 1'b0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_done got=%b/%h/%b/%h/%b want=0/0/0/00/1",
        out_valid, out_result, carry_flag, ops_done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rst_release got=%b/%b want=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic [7:0]  r;
    logic [3:0]  pa, pb;
    logic [2:0]  pop;
    logic        pch, pend, mc, mb, eir, ev;
    int unsigned mops;
    do_reset();
    pend = 1'b0; mc = 1'b0; mb = 1'b0; mops = 0;
    pa = '0; pb = '0; pop = '0; pch = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flag_clr  = ($urandom % 16) == 0;
      in_a = 4'($urandom); in_b = 4'($urandom);
      in_op = 3'($urandom); in_chain = 1'($urandom);
      @(negedge clk);
      ev  = exp_q.size() > 0;
      eir = !pend && (!ev || out_ready);
      total++;
      if ({out_valid, in_ready, carry_flag, borrow_flag, ops_done} !==
          {ev, eir, mc, mb, 8'(mops)}) begin
        bad++;
        $display("FAIL rnd_status c%0d got=%b/%b/%b/%b/%h want=%b/%b/%b/%b/%h",
          cyc, out_valid, in_ready, carry_flag, borrow_flag, ops_done,
          ev, eir, mc, mb, 8'(mops));
      end
      if (ev && out_ready) begin
        e = exp_q.pop_front();
        mops++;
        total++;
        if ({out_result, out_carry, out_borrow, out_cmp, out_op} !== e) begin
          bad++;
          $display("FAIL rnd_result c%0d got=%h/%b/%b/%b/%b want=%h/%b/%b/%b/%b",
            cyc, out_result, out_carry, out_borrow, out_cmp, out_op,
            e[10:7], e[6], e[5], e[4:3], e[2:0]);
        end
      end
      if (pend) begin
        r = alu_ref(pa, pb, pop, pch & mc, pch & mb);
        exp_q.push_back({r, pop});
        if (pop == 3'b001) mc = r[3];
        if (pop == 3'b010) mb = r[2];
        pend = 1'b0;
      end
      if (flag_clr) begin
        mc = 1'b0; mb = 1'b0;
      end
      if (in_valid && eir) begin
        pend = 1'b1;
        pa = in_a; pb = in_b; pop = in_op; pch = in_chain;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    total++;
    if (mops < 300) begin
      bad++;
      $display("FAIL rnd_coverage got=%0d want>=300", mops);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_carry_chain();
    test_borrow_chain();
    test_back_pressure();
    test_flag_clr();
    test_cmp_shift();
    test_reset_in_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
